// File: rtl/up_control_unit_if.sv
// Purpose: control/flag bundle between the up_control_unit FSM and the accumulator datapath.
// Latency: pure wiring, no storage.
// Backpressure: none; the only wait condition is the ENTER key level carried here.
interface up_control_unit_if;
    logic [2:0] IR;       // opcode IR[7:5]
    logic       Aeq0;     // accumulator == 0
    logic       Apos;     // accumulator MSB == 0
    logic       ENTER;    // user enter key, level
    logic       IRload;
    logic       PCload;
    logic       JMPmux;
    logic       Meminst;
    logic       MemWr;
    logic       Aload;
    logic       Sub;
    logic [1:0] Asel;
    logic       HALTED;
    logic [3:0] STATE;

    // Control unit side: reads opcode/flags/key, drives strobes
    modport master (
        input  IR, Aeq0, Apos, ENTER,
        output IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Asel, HALTED, STATE
    );

    // Datapath side: supplies opcode/flags/key, consumes strobes
    modport slave (
        output IR, Aeq0, Apos, ENTER,
        input  IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Asel, HALTED, STATE
    );
endinterface

// File: rtl/up_control_unit.sv
// Purpose: fetch/decode/execute sequencer driving all datapath strobes of the 8-bit accumulator CPU.
// Latency: 3 cycles per non-IN instruction; IN waits for ENTER (+2 cycles when ENTER is synchronised).
// Backpressure: none downstream; IN stalls in INPUT until ENTER, then in INREL until ENTER is released.
module up_control_unit #(
    parameter bit ENTER_SYNC = 1'b1
) (
    input  logic          CLOCK,
    input  logic          RESET,
    up_control_unit_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        LOAD   = 4'd2,
        STORE  = 4'd3,
        ADD    = 4'd4,
        SUB    = 4'd5,
        INPUT  = 4'd6,
        INREL  = 4'd7,
        JZ     = 4'd8,
        JPOS   = 4'd9,
        HALT   = 4'd10
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   enter_s1;
    logic   enter_s2;
    logic   enter_q;

    // Two-flop synchroniser for the asynchronous ENTER key
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            enter_s1 <= 1'b0;
            enter_s2 <= 1'b0;
        end else begin
            enter_s1 <= bus.ENTER;
            enter_s2 <= enter_s1;
        end
    end

    assign enter_q = ENTER_SYNC ? enter_s2 : bus.ENTER;

    // State register; reset overrides every state including INPUT and HALT
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode; outputs are Moore except PCload in JZ/JPOS and Aload in INPUT
    always_comb begin
        state_nxt   = FETCH;
        bus.IRload  = 1'b0;
        bus.PCload  = 1'b0;
        bus.JMPmux  = 1'b0;
        bus.Meminst = 1'b0;
        bus.MemWr   = 1'b0;
        bus.Aload   = 1'b0;
        bus.Sub     = 1'b0;
        bus.Asel    = 2'b00;
        bus.HALTED  = 1'b0;
        bus.STATE   = state;
        case (state)
            FETCH: begin
                bus.IRload = 1'b1;
                bus.PCload = 1'b1;
                bus.JMPmux = 1'b1;
                state_nxt  = DECODE;
            end
            DECODE: begin
                bus.Meminst = 1'b1;
                case (bus.IR)
                    3'b000:  state_nxt = LOAD;
                    3'b001:  state_nxt = STORE;
                    3'b010:  state_nxt = ADD;
                    3'b011:  state_nxt = SUB;
                    3'b100:  state_nxt = INPUT;
                    3'b101:  state_nxt = JZ;
                    3'b110:  state_nxt = JPOS;
                    default: state_nxt = HALT;
                endcase
            end
            LOAD: begin
                bus.Meminst = 1'b1;
                bus.Asel    = 2'b10;
                bus.Aload   = 1'b1;
            end
            STORE: begin
                bus.Meminst = 1'b1;
                bus.MemWr   = 1'b1;
            end
            ADD: begin
                bus.Meminst = 1'b1;
                bus.Aload   = 1'b1;
            end
            SUB: begin
                bus.Meminst = 1'b1;
                bus.Sub     = 1'b1;
                bus.Aload   = 1'b1;
            end
            INPUT: begin
                // A is loaded only in the cycle the qualified key is seen
                bus.Asel  = 2'b01;
                bus.Aload = enter_q;
                state_nxt = enter_q ? INREL : INPUT;
            end
            INREL: begin
                // Wait for key release so one press gives exactly one load
                state_nxt = enter_q ? INREL : FETCH;
            end
            JZ: begin
                bus.PCload = bus.Aeq0;
            end
            JPOS: begin
                bus.PCload = bus.Apos;
            end
            HALT: begin
                bus.HALTED = 1'b1;
                state_nxt  = HALT;
            end
            default: begin
                // Illegal codes look halted for one cycle, then recover to FETCH
                bus.HALTED = 1'b1;
                state_nxt  = FETCH;
            end
        endcase
        if (!RESET) begin
            bus.IRload  = 1'b0;
            bus.PCload  = 1'b0;
            bus.JMPmux  = 1'b0;
            bus.Meminst = 1'b0;
            bus.MemWr   = 1'b0;
            bus.Aload   = 1'b0;
            bus.Sub     = 1'b0;
            bus.Asel    = 2'b00;
            bus.HALTED  = 1'b0;
            bus.STATE   = 4'd0;
        end
    end

endmodule

// File: tb/tb_up_control_unit.sv
// Purpose: self-checking bench for up_control_unit, both ENTER_SYNC variants side by side.
// Latency: outputs compared every negedge against an instruction-level reference model.
// Backpressure: n/a; stimulus is directed sequences followed by randomized opcode/flag/key/reset traffic.
module tb_up_control_unit;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [2:0] ir;
    logic       aeq0;
    logic       apos;
    logic       enter;

    int checks   = 0;
    int failures = 0;

    up_control_unit_if bus0 ();
    up_control_unit_if bus1 ();

    assign bus0.IR = ir;   assign bus0.Aeq0 = aeq0; assign bus0.Apos = apos; assign bus0.ENTER = enter;
    assign bus1.IR = ir;   assign bus1.Aeq0 = aeq0; assign bus1.Apos = apos; assign bus1.ENTER = enter;

    up_control_unit #(.ENTER_SYNC(1'b1)) dut0 (.CLOCK(CLOCK), .RESET(RESET), .bus(bus0));
    up_control_unit #(.ENTER_SYNC(1'b0)) dut1 (.CLOCK(CLOCK), .RESET(RESET), .bus(bus1));

    always #5 CLOCK = ~CLOCK;

    // Strobe vector: {IRload,PCload,JMPmux,Meminst,MemWr,Aload,Sub,Asel[1:0],HALTED}
    logic [9:0] out0;
    logic [9:0] out1;
    assign out0 = {bus0.IRload, bus0.PCload, bus0.JMPmux, bus0.Meminst, bus0.MemWr,
                   bus0.Aload, bus0.Sub, bus0.Asel, bus0.HALTED};
    assign out1 = {bus1.IRload, bus1.PCload, bus1.JMPmux, bus1.Meminst, bus1.MemWr,
                   bus1.Aload, bus1.Sub, bus1.Asel, bus1.HALTED};

    localparam logic [9:0] V_FETCH  = 10'b1110000000;
    localparam logic [9:0] V_DECODE = 10'b0001000000;
    localparam logic [9:0] V_NONE   = 10'b0000000000;

    // Strobes each state code asserts unconditionally (flag/key-dependent bits added later)
    localparam logic [9:0] BASE [11] = '{
        V_FETCH, V_DECODE,
        10'b0001010100,     // load:  Meminst, Aload, Asel=10
        10'b0001100000,     // store: Meminst, MemWr
        10'b0001010000,     // add:   Meminst, Aload
        10'b0001011000,     // sub:   Meminst, Aload, Sub
        10'b0000000010,     // input: Asel=01
        V_NONE,             // inrel
        V_NONE,             // jz
        V_NONE,             // jpos
        10'b0000000001      // halt
    };
    // Execute-phase state code reached from each opcode
    localparam int EXEC [8] = '{2, 3, 4, 5, 6, 8, 9, 10};

    // Reference model: [0] = synchronised key, [1] = direct key
    int m_st [2];
    bit m_q1 = 1'b0;
    bit m_q2 = 1'b0;
    bit m_valid = 1'b0;

    function automatic bit m_eq(input int v);
        return (v == 0) ? m_q2 : enter;
    endfunction

    function automatic logic [9:0] m_vec(input int v);
        logic [9:0] r;
        if (!RESET) return V_NONE;
        r = BASE[m_st[v]];
        if (m_st[v] == 8) r[8] = aeq0;
        if (m_st[v] == 9) r[8] = apos;
        if (m_st[v] == 6) r[4] = m_eq(v);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model one instruction-level step at every rising edge
    always @(posedge CLOCK) begin
        for (int v = 0; v < 2; v++) begin
            if (!RESET) m_st[v] = 0;
            else if (m_st[v] == 0) m_st[v] = 1;
            else if (m_st[v] == 1) m_st[v] = EXEC[ir];
            else if (m_st[v] == 6) m_st[v] = m_eq(v) ? 7 : 6;
            else if (m_st[v] == 7) m_st[v] = m_eq(v) ? 7 : 0;
            else if (m_st[v] == 10) m_st[v] = 10;
            else m_st[v] = 0;
        end
        if (!RESET) begin
            m_q1 = 1'b0;
            m_q2 = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_q2 = m_q1;
            m_q1 = enter;
        end
    end

    // Compare both DUTs against the model every cycle once the model is anchored by reset
    always @(negedge CLOCK) begin
        if (m_valid) begin
            check("sync1 strobes", out0, m_vec(0));
            check("sync1 state", bus0.STATE, RESET ? m_st[0] : 0);
            check("sync0 strobes", out1, m_vec(1));
            check("sync0 state", bus1.STATE, RESET ? m_st[1] : 0);
        end
    end

    task automatic cyc();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic expect_cyc(input string nm, input logic [9:0] vec, input int st);
        @(negedge CLOCK);
        check({nm, " strobes"}, out0, vec);
        check({nm, " state"}, bus0.STATE, st);
    endtask

    // Entered during a FETCH cycle (after its sample); leaves in the next FETCH cycle
    task automatic run_op(input logic [2:0] op, input logic a0, input logic ap,
                          input logic [9:0] vec, input int st, input string nm);
        cyc();
        ir = op; aeq0 = a0; apos = ap;
        expect_cyc({nm, " decode"}, V_DECODE, 1);
        cyc();
        expect_cyc(nm, vec, st);
        cyc();
        expect_cyc({nm, " refetch"}, V_FETCH, 0);
    endtask

    logic       rec_aload [12];
    logic [3:0] rec_st [12];
    int         npulse;
    int         pidx;

    initial begin
        RESET = 1'b0; ir = 3'b010; enter = 1'b1; aeq0 = 1'b0; apos = 1'b0;
        repeat (3) begin
            cyc();
            expect_cyc("in reset", V_NONE, 0);
        end
        cyc();
        RESET = 1'b1; enter = 1'b0;
        expect_cyc("first fetch", V_FETCH, 0);

        run_op(3'b000, 1'b0, 1'b0, 10'b0001010100, 2, "load");
        run_op(3'b001, 1'b0, 1'b0, 10'b0001100000, 3, "store");
        run_op(3'b011, 1'b0, 1'b0, 10'b0001011000, 5, "sub");
        run_op(3'b010, 1'b0, 1'b0, 10'b0001010000, 4, "add");
        run_op(3'b101, 1'b1, 1'b0, 10'b0100000000, 8, "jz taken");
        run_op(3'b101, 1'b0, 1'b1, V_NONE,         8, "jz not taken");
        run_op(3'b110, 1'b0, 1'b1, 10'b0100000000, 9, "jpos taken");
        run_op(3'b110, 1'b1, 1'b0, V_NONE,         9, "jpos not taken");

        // IN: wait with key up, then one 6-cycle key press
        cyc();
        ir = 3'b100;
        expect_cyc("in decode", V_DECODE, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            expect_cyc("in waiting", 10'b0000000010, 6);
        end
        cyc();
        enter = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLOCK);
            rec_aload[k] = bus0.Aload;
            rec_st[k]    = bus0.STATE;
            cyc();
            if (k == 5) enter = 1'b0;
            if (k == 9) ir = 3'b111;
        end
        npulse = 0;
        pidx   = -1;
        for (int k = 0; k < 12; k++) begin
            if (rec_aload[k] === 1'b1) begin
                npulse++;
                if (pidx < 0) pidx = k;
            end
        end
        check("key aload count", npulse, 1);
        check("key aload delay", pidx, 2);
        check("key held state", rec_st[1], 6);
        check("key released inrel", rec_st[8], 7);
        check("key release fetch", rec_st[9], 0);

        // Now in HALT (decoded 111 after the IN completed)
        for (int i = 0; i < 10; i++) begin
            expect_cyc("halt", 10'b0000000001, 10);
            cyc();
        end
        RESET = 1'b0; ir = 3'b100;
        expect_cyc("reset in halt", V_NONE, 0);
        cyc();
        RESET = 1'b1;
        expect_cyc("fetch after halt", V_FETCH, 0);
        cyc();
        expect_cyc("in decode 2", V_DECODE, 1);
        cyc();
        expect_cyc("in wait 2", 10'b0000000010, 6);
        cyc();
        RESET = 1'b0;
        expect_cyc("reset in input", V_NONE, 0);
        cyc();
        RESET = 1'b1;
        expect_cyc("fetch after input", V_FETCH, 0);

        // Randomized traffic; the compare process does the checking
        for (int n = 0; n < 3000; n++) begin
            cyc();
            ir    = 3'($urandom_range(0, 7));
            aeq0  = 1'($urandom_range(0, 1));
            apos  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) enter = ~enter;
            RESET = ($urandom_range(0, 31) != 0);
        end
        cyc();
        RESET = 1'b1;
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
